// File: rtl/uart_autobaud_pkg.sv
// Shared constants, state encoding and helpers for the UART auto-baud calibrator.
package uart_autobaud_pkg;

  localparam logic [7:0] SYNC_CHAR    = 8'h55;
  localparam logic [3:0] AB_EDGES     = 4'd10;
  localparam int         AB_TOL_SHIFT = 2;

  typedef logic [1:0] ab_state_t;

  localparam ab_state_t ST_IDLE    = 2'd0;
  localparam ab_state_t ST_ARM     = 2'd1;
  localparam ab_state_t ST_START   = 2'd2;
  localparam ab_state_t ST_MEASURE = 2'd3;

  // Eight-bit total to clocks-per-bit, rounded to nearest and clamped to 16 bits.
  function automatic logic [15:0] div_round(input logic [18:0] tot);
    logic [19:0] r;
    r = ({1'b0, tot} + 20'd4) >> 3;
    return (r > 20'h0FFFF) ? 16'hFFFF : r[15:0];
  endfunction

endpackage

// File: rtl/ab_edge_sync.sv
// Two-flop synchronizer plus delay flop; flags falling and rising edges of an async line.
module ab_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din,
  output logic s2,
  output logic fall,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic s2_d_reg;

  // Flops reset high so an idle (high) line never shows a spurious edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_reg   <= 1'b1;
      s2_reg   <= 1'b1;
      s2_d_reg <= 1'b1;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      s2_d_reg <= s2_reg;
    end
  end

  assign s2   = s2_reg;
  assign fall = s2_d_reg & ~s2_reg;
  assign rise = ~s2_d_reg & s2_reg;

endmodule

// File: rtl/uart_autobaud.sv
// Measures the bit period of a received 0x55 sync character and loads the receiver divisor.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter logic [15:0] MIN_BIT     = 16'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        rx_bit_i,
  output logic [15:0] baud_div_o,
  output logic        rx_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  logic s2;
  logic fall;
  logic rise;
  logic edge_any;

  ab_edge_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .din   (rx_bit_i),
    .s2    (s2),
    .fall  (fall),
    .rise  (rise)
  );

  assign edge_any = fall | rise;

  ab_state_t   state_reg;
  logic [15:0] ivl_cnt_reg;
  logic [18:0] tot_cnt_reg;
  logic [15:0] ref_reg;
  logic [3:0]  edge_cnt_reg;
  logic        idle_seen_reg;
  logic [15:0] div_reg;
  logic        rx_en_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;

  logic [16:0] ivl_p1;
  logic [16:0] tol;
  logic [16:0] hi_lim;
  logic [16:0] lo_lim;
  logic [18:0] tot_p1;
  logic        ivl_ok;
  logic        go_abort;
  logic        go_err;
  logic        go_ok;

  // The interval is ivl_cnt+1 because the edge cycle itself belongs to it.
  assign ivl_p1 = {1'b0, ivl_cnt_reg} + 17'd1;
  assign tol    = {1'b0, ref_reg >> AB_TOL_SHIFT};
  assign hi_lim = {1'b0, ref_reg} + tol;
  assign lo_lim = {1'b0, ref_reg} - tol;
  assign tot_p1 = tot_cnt_reg + 19'd1;
  assign ivl_ok = (ivl_p1 >= lo_lim) && (ivl_p1 <= hi_lim);

  always_comb begin
    go_abort = abort_i && (state_reg != ST_IDLE);
    go_err   = 1'b0;
    go_ok    = 1'b0;
    case (state_reg)
      ST_START: begin
        go_err = (ivl_cnt_reg == 16'hFFFF) || (rise && (ivl_p1 < {1'b0, MIN_BIT}));
      end
      ST_MEASURE: begin
        // Without an edge, running past the upper tolerance means the character is not 0x55.
        go_err = edge_any ? !ivl_ok : (ivl_p1 > hi_lim);
        go_ok  = edge_any && ivl_ok && (edge_cnt_reg == AB_EDGES - 4'd1);
      end
      default: begin
        go_err = 1'b0;
        go_ok  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      ivl_cnt_reg   <= 16'd0;
      tot_cnt_reg   <= 19'd0;
      ref_reg       <= 16'd0;
      edge_cnt_reg  <= 4'd0;
      idle_seen_reg <= 1'b0;
      div_reg       <= DEFAULT_DIV;
      rx_en_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (ivl_cnt_reg != 16'hFFFF) begin
        ivl_cnt_reg <= ivl_cnt_reg + 16'd1;
      end

      if (go_abort) begin
        state_reg <= ST_IDLE;
        rx_en_reg <= 1'b1;
        busy_reg  <= 1'b0;
      end else if (go_err) begin
        state_reg <= ST_IDLE;
        err_reg   <= 1'b1;
        rx_en_reg <= 1'b1;
        busy_reg  <= 1'b0;
      end else if (go_ok) begin
        state_reg <= ST_IDLE;
        div_reg   <= div_round(tot_p1);
        rx_en_reg <= 1'b1;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_i && !abort_i) begin
              state_reg     <= ST_ARM;
              rx_en_reg     <= 1'b0;
              busy_reg      <= 1'b1;
              err_reg       <= 1'b0;
              ivl_cnt_reg   <= 16'd0;
              tot_cnt_reg   <= 19'd0;
              ref_reg       <= 16'd0;
              edge_cnt_reg  <= 4'd0;
              idle_seen_reg <= 1'b0;
            end
          end
          ST_ARM: begin
            // A line found low at request time must go idle before a fall counts as a start bit.
            if (!idle_seen_reg) begin
              if (s2) begin
                idle_seen_reg <= 1'b1;
              end
            end else if (fall) begin
              ivl_cnt_reg  <= 16'd0;
              edge_cnt_reg <= 4'd1;
              state_reg    <= ST_START;
            end
          end
          ST_START: begin
            if (rise) begin
              ref_reg      <= ivl_p1[15:0];
              ivl_cnt_reg  <= 16'd0;
              tot_cnt_reg  <= 19'd0;
              edge_cnt_reg <= 4'd2;
              state_reg    <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            tot_cnt_reg <= tot_p1;
            if (edge_any) begin
              ivl_cnt_reg  <= 16'd0;
              edge_cnt_reg <= edge_cnt_reg + 4'd1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign baud_div_o = div_reg;
  assign rx_en_o    = rx_en_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_uart_autobaud.sv
// Scenario bench for uart_autobaud: directed cases plus randomized frames against a run-length model.
module tb_uart_autobaud;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        rx_bit_i = 1'b1;
  logic [15:0] baud_div_o;
  logic        rx_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  uart_autobaud #(.DEFAULT_DIV(16'd868), .MIN_BIT(16'd4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .rx_bit_i   (rx_bit_i),
    .baud_div_o (baud_div_o),
    .rx_en_o    (rx_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic [15:0] exp_div = 16'd868;
  int          frame_q[$];
  int          dur[9];

  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

  task automatic do_start;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  // Drives alternating low/high runs from frame_q, then leaves the line idle high.
  task automatic send_frame;
    logic lvl;
    lvl = 1'b0;
    foreach (frame_q[i]) begin
      rx_bit_i = lvl;
      repeat (frame_q[i]) begin @(posedge clk_i); #1; end
      lvl = ~lvl;
    end
    rx_bit_i = 1'b1;
  endtask

  task automatic rand_dur(input int p, input int jit);
    for (int k = 0; k < 9; k++) dur[k] = p - jit + int'($urandom_range(0, 2 * jit));
  endtask

  // Start bit plus 8 data bits (LSB first) collapsed into line runs; a trailing high run merges into idle.
  task automatic build_frame(input logic [7:0] byt);
    logic b[9];
    logic cur;
    int   run;
    b[0] = 1'b0;
    for (int k = 1; k < 9; k++) b[k] = byt[k-1];
    frame_q.delete();
    cur = 1'b0;
    run = dur[0];
    for (int k = 1; k < 9; k++) begin
      if (b[k] == cur) run += dur[k];
      else begin frame_q.push_back(run); cur = b[k]; run = dur[k]; end
    end
    if (cur == 1'b0) frame_q.push_back(run);
  endtask

  // First low run is the reference; the next eight runs must each lie within ref/4 of it.
  task automatic model(output bit ok, output logic [15:0] div);
    int rw, tol, tot, d, q;
    ok = 1'b0;
    div = exp_div;
    if (frame_q.size() == 0) return;
    rw = frame_q[0];
    if (rw < 4) return;
    tol = rw >> 2;
    tot = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k >= frame_q.size()) return;
      d = frame_q[k];
      if (d > rw + tol || d < rw - tol) return;
      tot += d;
    end
    ok = 1'b1;
    q = (tot + 4) >> 3;
    div = (q > 65535) ? 16'hFFFF : q[15:0];
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy_o === 1'b1 && k < budget) begin @(negedge clk_i); k++; end
    if (busy_o !== 1'b0) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: busy_o=%b still high after %0d cycles, required 0", tag, busy_o, budget);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic drive_cal(input string tag, output int pulses);
    int d0, sum;
    d0 = done_cnt;
    sum = 0;
    foreach (frame_q[i]) sum += frame_q[i];
    do_start;
    send_frame;
    wait_idle(2 * sum + 200, tag);
    pulses = done_cnt - d0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (baud_div_o !== 16'd868 || rx_en_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: div=%0d en=%b busy=%b done=%b err=%b, required 868 1 0 0 0",
               baud_div_o, rx_en_o, busy_o, done_o, err_o);
    end
    $display("reset: div=%0d en=%b busy=%b", baud_div_o, rx_en_o, busy_o);
  endtask

  task automatic test_basic;
    int d0;
    rand_dur(100, 0);
    build_frame(8'h55);
    d0 = done_cnt;
    do_start;
    send_frame;
    @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b1 || rx_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy: busy=%b en=%b, required 1 0", busy_o, rx_en_o);
    end
    @(negedge clk_i); @(negedge clk_i);
    n_vec++;
    if (done_o !== 1'b0) begin n_bad++; $display("FAIL basic_early_done: done=%b, required 0", done_o); end
    @(negedge clk_i);
    n_vec++;
    if (done_o !== 1'b1) begin n_bad++; $display("FAIL basic_latency: done=%b 3 clk after stop rise, required 1", done_o); end
    wait_idle(100, "basic");
    n_vec++;
    if (baud_div_o !== 16'd100 || done_cnt - d0 != 1 || err_o !== 1'b0 || rx_en_o !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_result: div=%0d pulses=%0d err=%b en=%b, required 100 1 0 1",
               baud_div_o, done_cnt - d0, err_o, rx_en_o);
    end
    exp_div = 16'd100;
    $display("basic 0x55 @100: div=%0d pulses=%0d", baud_div_o, done_cnt - d0);
  endtask

  task automatic test_bad_char;
    int p;
    rand_dur(100, 0);
    build_frame(8'h00);
    drive_cal("bad_char", p);
    n_vec++;
    if (err_o !== 1'b1 || baud_div_o !== exp_div || rx_en_o !== 1'b1 || p != 0) begin
      n_bad++;
      $display("FAIL bad_char: err=%b div=%0d en=%b pulses=%0d, required 1 %0d 1 0", err_o, baud_div_o, rx_en_o, p, exp_div);
    end
    $display("bad char 0x00: err=%b div=%0d", err_o, baud_div_o);
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    frame_q.delete();
    frame_q.push_back(2);
    do_start;
    @(negedge clk_i);
    n_vec++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clear: err=%b after start, required 0", err_o); end
    send_frame;
    wait_idle(200, "glitch");
    n_vec++;
    if (err_o !== 1'b1 || baud_div_o !== exp_div || done_cnt != d0) begin
      n_bad++;
      $display("FAIL glitch: err=%b div=%0d pulses=%0d, required 1 %0d 0", err_o, baud_div_o, done_cnt - d0, exp_div);
    end
    $display("glitch 2clk: err=%b", err_o);
  endtask

  task automatic test_fractional;
    int p;
    for (int k = 0; k < 9; k++) dur[k] = (k % 2 == 1) ? 867 : 868;
    build_frame(8'h55);
    drive_cal("fractional", p);
    n_vec++;
    if (baud_div_o !== 16'd868 || p != 1 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fractional: div=%0d pulses=%0d err=%b, required 868 1 0", baud_div_o, p, err_o);
    end
    exp_div = 16'd868;
    $display("fractional 867/868: div=%0d", baud_div_o);
  endtask

  task automatic test_line_low;
    int d0;
    rand_dur(100, 0);
    build_frame(8'h55);
    d0 = done_cnt;
    @(posedge clk_i); #1 rx_bit_i = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    do_start;
    repeat (50) @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b1 || rx_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL line_low_arm: busy=%b en=%b, required 1 0", busy_o, rx_en_o);
    end
    @(posedge clk_i); #1 rx_bit_i = 1'b1;
    repeat (20) begin @(posedge clk_i); #1; end
    fork
      send_frame;
      begin
        repeat (300) @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
      end
    join
    wait_idle(500, "line_low");
    n_vec++;
    if (baud_div_o !== 16'd100 || done_cnt - d0 != 1 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL line_low: div=%0d pulses=%0d err=%b, required 100 1 0", baud_div_o, done_cnt - d0, err_o);
    end
    exp_div = 16'd100;
    $display("line low then 0x55 with re-start: div=%0d pulses=%0d", baud_div_o, done_cnt - d0);
  endtask

  task automatic test_abort;
    int d0;
    d0 = done_cnt;
    do_start;
    rx_bit_i = 1'b0; repeat (100) begin @(posedge clk_i); #1; end
    rx_bit_i = 1'b1; repeat (100) begin @(posedge clk_i); #1; end
    rx_bit_i = 1'b0; repeat (50)  begin @(posedge clk_i); #1; end
    abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b0 || rx_en_o !== 1'b1 || baud_div_o !== exp_div || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: busy=%b en=%b div=%0d err=%b, required 0 1 %0d 0", busy_o, rx_en_o, baud_div_o, err_o, exp_div);
    end
    rx_bit_i = 1'b1;
    repeat (200) @(negedge clk_i);
    n_vec++;
    if (done_cnt != d0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet: pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy_o);
    end
    $display("abort mid-measure: busy=%b div=%0d", busy_o, baud_div_o);
  endtask

  task automatic test_reset_mid;
    do_start;
    rx_bit_i = 1'b0; repeat (100) begin @(posedge clk_i); #1; end
    rx_bit_i = 1'b1; repeat (60)  begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (baud_div_o !== 16'd868 || rx_en_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: div=%0d en=%b busy=%b done=%b err=%b, required 868 1 0 0 0",
               baud_div_o, rx_en_o, busy_o, done_o, err_o);
    end
    exp_div = 16'd868;
    repeat (20) @(negedge clk_i);
    $display("reset mid-measure: div=%0d", baud_div_o);
  endtask

  task automatic test_random;
    logic [7:0]  byt;
    logic [15:0] div;
    bit          ok;
    int          per, p;
    for (int n = 0; n < 8; n++) begin
      byt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h55;
      per = int'($urandom_range(8, 200));
      rand_dur(per, per / 16);
      build_frame(byt);
      model(ok, div);
      drive_cal("random", p);
      n_vec++;
      if (baud_div_o !== div || err_o !== !ok || p != (ok ? 1 : 0) || rx_en_o !== 1'b1) begin
        n_bad++;
        $display("FAIL random[%0d]: byte=%02h div=%0d err=%b pulses=%0d en=%b, required %0d %b %0d 1",
                 n, byt, baud_div_o, err_o, p, rx_en_o, div, !ok, ok ? 1 : 0);
      end
      exp_div = div;
      $display("random[%0d]: byte=%02h period=%0d div=%0d err=%b", n, byt, per, baud_div_o, err_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_char;
    test_glitch;
    test_fractional;
    test_line_low;
    test_abort;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
